// File: rtl/adc_frame_pkg.sv
// Shared constants and types for the ADC frame streamer: frame geometry,
// field offsets and the streaming FSM state encoding.
package adc_frame_pkg;

    localparam int FRAME_W = 256;
    localparam int WORD_W  = 32;
    localparam int BEATS   = FRAME_W / WORD_W;
    localparam int BEAT_W  = $clog2(BEATS);

    localparam int NS_LSB  = 244;
    localparam int CNT_LSB = 192;
    localparam int CH_W    = 24;
    localparam int NUM_CH  = CNT_LSB / CH_W;

    localparam logic [BEAT_W-1:0] FIRST_BEAT = '0;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

    // Channel 0 occupies the most significant channel slot.
    typedef struct packed {
        logic [FRAME_W-NS_LSB-1:0]          nsamples;
        logic [NS_LSB-CNT_LSB-1:0]          counter;
        logic [0:NUM_CH-1][CH_W-1:0]        ch;
    } frame_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

endpackage

// File: rtl/adc_frame_fifo.sv
// DEPTH-entry frame FIFO; head is read from registered storage at the
// registered read pointer, and a push into a full FIFO is legal when a pop
// retires the head in the same cycle.
module adc_frame_fifo
    import adc_frame_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  frame_t                   push_data,
    input  logic                     pop,
    output frame_t                   head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    frame_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; level and pointers define which
    // entries are meaningful, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_streamer.sv
// Buffers 256-bit ADC frames and streams each as an 8-beat 32-bit
// Avalon-ST packet, MSW first, dropping and counting frames when full.
module adc_frame_streamer
    import adc_frame_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OVF_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [FRAME_W-1:0]       frame_data,
    input  logic                     frame_valid,
    output logic [WORD_W-1:0]        st_data,
    output logic                     st_valid,
    input  logic                     st_ready,
    output logic                     st_sop,
    output logic                     st_eop,
    output logic [OVF_W-1:0]         overflow_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    state_t               state;
    logic [FRAME_W-1:0]   shreg;
    logic [BEAT_W-1:0]    beat;

    frame_t               fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 last_accept;

    // A pop in the same cycle frees a slot, so a full FIFO can still take
    // the incoming frame when the current packet is finishing.
    assign last_accept = (state == SEND) && st_ready && (beat == LAST_BEAT);
    assign pop         = !fifo_empty && ((state == IDLE) || last_accept);
    assign push        = frame_valid && enable && (!fifo_full || pop);
    assign drop        = frame_valid && enable && fifo_full && !pop;

    adc_frame_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (frame_t'(frame_data)),
        .pop       (pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign st_data = shreg[FRAME_W-1 -: WORD_W];
    assign busy    = st_valid || (fifo_level != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_count <= '0;
        end else if (drop && (overflow_count != {OVF_W{1'b1}})) begin
            overflow_count <= overflow_count + OVF_W'(1);
        end
    end

    // st_valid/sop/eop are flops so nothing combinational reaches them from st_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            beat     <= FIRST_BEAT;
            st_valid <= 1'b0;
            st_sop   <= 1'b0;
            st_eop   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg    <= fifo_head;
                        beat     <= FIRST_BEAT;
                        state    <= SEND;
                        st_valid <= 1'b1;
                        st_sop   <= 1'b1;
                        st_eop   <= 1'b0;
                    end
                end
                SEND: begin
                    if (st_ready) begin
                        if (beat == LAST_BEAT) begin
                            if (!fifo_empty) begin
                                shreg  <= fifo_head;
                                beat   <= FIRST_BEAT;
                                st_sop <= 1'b1;
                                st_eop <= 1'b0;
                            end else begin
                                state    <= IDLE;
                                st_valid <= 1'b0;
                                st_sop   <= 1'b0;
                                st_eop   <= 1'b0;
                            end
                        end else begin
                            shreg  <= shreg << WORD_W;
                            beat   <= beat + BEAT_W'(1);
                            st_sop <= 1'b0;
                            st_eop <= (beat == LAST_BEAT - BEAT_W'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
